// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: source indices for the one-hot "out" strobes
// and default widths used by the bus multiplexer and the control unit.
package cpu_bus_pkg;

  localparam int WORD_W        = 32;
  localparam int N_SRC_DEFAULT = 24;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  // Index width for n sources; a single source still needs one bit of port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_prio_encoder.sv
// Fixed-priority encoder for one-hot request strobes: lowest set bit wins.
// Also reports whether any request is present and whether several are.
module bus_prio_encoder
  import cpu_bus_pkg::*;
#(
  parameter  int N_SRC = N_SRC_DEFAULT,
  localparam int SEL_W = sel_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o = '0;
    // Scan from the top so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = SEL_W'(i);
    end
  end

  assign any_o   = |req_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(req_i & (req_i - 1'b1));

endmodule

// File: rtl/bus_source_mux_reg.sv
// Registered CPU bus multiplexer: resolves one-hot source strobes by fixed
// priority, loads the winning word onto the bus and tracks driver conflicts.
module bus_source_mux_reg
  import cpu_bus_pkg::*;
#(
  parameter  int WIDTH   = WORD_W,
  parameter  int N_SRC   = N_SRC_DEFAULT,
  parameter  bit HOLD_EN = 1'b1,
  parameter  int CNT_W   = 8,
  localparam int SEL_W   = sel_width(N_SRC)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_out,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [SEL_W-1:0]       bus_sel,
  output logic                   conflict,
  output logic                   conflict_sticky,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEL_W-1:0] idx;
  logic             any;
  logic             multi;
  logic [WIDTH-1:0] sel_word;

  logic [WIDTH-1:0] bus_q,      bus_d;
  logic             valid_q,    valid_d;
  logic [SEL_W-1:0] sel_q,      sel_d;
  logic             conflict_q, conflict_d;
  logic             sticky_q,   sticky_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  bus_prio_encoder #(
    .N_SRC (N_SRC)
  ) u_prio (
    .req_i   (src_out),
    .idx_o   (idx),
    .any_o   (any),
    .multi_o (multi)
  );

  // AND-OR word select: only the winning source reaches the bus, so unknown
  // data on idle sources cannot leak through.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (any && idx == SEL_W'(i)) sel_word = src_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus_d      = bus_q;
    sel_d      = sel_q;
    valid_d    = any;
    conflict_d = multi;
    if (any) begin
      bus_d = sel_word;
      sel_d = idx;
    end else if (!HOLD_EN) begin
      bus_d = '0;
    end
    // A clear and a fresh conflict on the same edge: clear first, then count.
    sticky_d = (sticky_q & ~err_clr) | multi;
    cnt_d    = err_clr ? '0 : cnt_q;
    if (multi && cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      sel_q      <= '0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_out         = bus_q;
  assign bus_valid       = valid_q;
  assign bus_sel         = sel_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;
  assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_source_mux_reg.sv
// Bench for bus_source_mux_reg: three instances (default, no-hold, 2-bit
// counter) share stimulus and are compared every cycle to a behavioural model.
module tb_bus_source_mux_reg;

  localparam int W  = 32;
  localparam int NS = 24;

  logic            clk = 1'b0;
  logic            clr;
  logic [NS*W-1:0] src_data;
  logic [NS-1:0]   src_out;
  logic            err_clr;

  logic [W-1:0] bus_a, bus_b, bus_c;
  logic         val_a, val_b, val_c;
  logic [4:0]   sel_a, sel_b, sel_c;
  logic         cf_a, cf_b, cf_c;
  logic         st_a, st_b, st_c;
  logic [7:0]   cnt_a, cnt_b;
  logic [1:0]   cnt_c;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  bus_source_mux_reg dut (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(bus_a), .bus_valid(val_a), .bus_sel(sel_a), .conflict(cf_a),
    .conflict_sticky(st_a), .conflict_cnt(cnt_a));

  bus_source_mux_reg #(.HOLD_EN(1'b0)) dut_nh (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(bus_b), .bus_valid(val_b), .bus_sel(sel_b), .conflict(cf_b),
    .conflict_sticky(st_b), .conflict_cnt(cnt_b));

  bus_source_mux_reg #(.CNT_W(2)) dut_c2 (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(bus_c), .bus_valid(val_c), .bus_sel(sel_c), .conflict(cf_c),
    .conflict_sticky(st_c), .conflict_cnt(cnt_c));

  // Behavioural view of the bus: what a software model of the datapath sees.
  typedef struct {
    logic [31:0] bus;
    int          sel;
    bit          valid;
    bit          conf;
    bit          sticky;
    int          cnt;
  } model_t;

  model_t m_a, m_b, m_c;

  typedef struct {
    logic [NS-1:0] so;
    logic          ec;
    logic [31:0]   bus;
    logic [4:0]    sel;
    logic          v;
    logic          c;
    logic          s;
    logic [7:0]    cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic model_t model_reset();
    model_t m;
    m.bus = 0; m.sel = 0; m.valid = 0; m.conf = 0; m.sticky = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input bit hold, input int cmax,
                                        input logic [NS-1:0] so, input bit ec,
                                        input logic [NS*W-1:0] data);
    model_t r = m;
    int n = $countones(so);
    int win = -1;
    for (int i = 0; i < NS; i++) if (so[i] && win < 0) win = i;
    r.valid = (n > 0);
    r.conf  = (n > 1);
    if (n > 0) begin
      r.bus = data[win*W +: W];
      r.sel = win;
    end else if (!hold) begin
      r.bus = 0;
    end
    if (ec) begin
      r.cnt = 0;
      r.sticky = 0;
    end
    if (n > 1) begin
      r.sticky = 1;
      r.cnt = (r.cnt + 1 > cmax) ? cmax : r.cnt + 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_inst(input string tag, input model_t m, input logic [31:0] bus,
                            input logic [4:0] sel, input logic v, input logic c,
                            input logic s, input logic [31:0] cnt);
    check({tag, ".bus"}, bus, m.bus);
    check({tag, ".sel"}, {27'd0, sel}, m.sel);
    check({tag, ".valid"}, {31'd0, v}, {31'd0, m.valid});
    check({tag, ".conflict"}, {31'd0, c}, {31'd0, m.conf});
    check({tag, ".sticky"}, {31'd0, s}, {31'd0, m.sticky});
    check({tag, ".cnt"}, cnt, m.cnt);
  endtask

  task automatic check_models();
    check_inst("hold", m_a, bus_a, sel_a, val_a, cf_a, st_a, {24'd0, cnt_a});
    check_inst("nohold", m_b, bus_b, sel_b, val_b, cf_b, st_b, {24'd0, cnt_b});
    check_inst("cnt2", m_c, bus_c, sel_c, val_c, cf_c, st_c, {30'd0, cnt_c});
  endtask

  // One clock: the models advance on the edge, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (clr) begin
      m_a = model_reset(); m_b = model_reset(); m_c = model_reset();
    end else begin
      m_a = model_step(m_a, 1'b1, 255, src_out, err_clr, src_data);
      m_b = model_step(m_b, 1'b0, 255, src_out, err_clr, src_data);
      m_c = model_step(m_c, 1'b1, 3, src_out, err_clr, src_data);
    end
    #1;
    check_models();
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge.
  task automatic pulse_reset();
    clr = 1'b1;
    #2;
    m_a = model_reset(); m_b = model_reset(); m_c = model_reset();
    check("async_reset.bus", bus_a, 32'd0);
    check("async_reset.valid", {31'd0, val_a}, 32'd0);
    check_models();
    clr = 1'b0;
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    src_data[i*W +: W] = v;
  endtask

  initial begin
    // R3=0x33, HI=0x16, every other word 0x1000_0000+i.
    vecs[0] = '{24'h000000, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{24'h010008, 1'b0, 32'h0000_0033, 5'd3,  1'b1, 1'b1, 1'b1, 8'd1};
    vecs[2] = '{24'h000000, 1'b0, 32'h0000_0033, 5'd3,  1'b0, 1'b0, 1'b1, 8'd1};
    vecs[3] = '{24'h010000, 1'b0, 32'h0000_0016, 5'd16, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[4] = '{24'h810000, 1'b0, 32'h0000_0016, 5'd16, 1'b1, 1'b1, 1'b1, 8'd2};
    vecs[5] = '{24'hFFFFFF, 1'b0, 32'h1000_0000, 5'd0,  1'b1, 1'b1, 1'b1, 8'd3};
    vecs[6] = '{24'h000028, 1'b1, 32'h0000_0033, 5'd3,  1'b1, 1'b1, 1'b1, 8'd1};
    vecs[7] = '{24'h000000, 1'b1, 32'h0000_0033, 5'd3,  1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8] = '{24'h800000, 1'b1, 32'h1000_0017, 5'd23, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9] = '{24'h000800, 1'b0, 32'h1000_000B, 5'd11, 1'b1, 1'b0, 1'b0, 8'd0};

    clr = 1'b1; src_out = '0; err_clr = 1'b0; src_data = '0;
    #3;
    m_a = model_reset(); m_b = model_reset(); m_c = model_reset();
    check_models();
    clr = 1'b0;

    // Reset in the middle of operation, then PC drives on the first edge.
    set_word(0, 32'h0000_00A5);
    src_out = 24'h000001;
    tick();
    check("pre_reset.bus", bus_a, 32'h0000_00A5);
    src_out = '0;
    pulse_reset();
    set_word(20, 32'h0000_0100);
    src_out = 24'h1 << 20;
    tick();
    check("pc.bus", bus_a, 32'h0000_0100);
    check("pc.sel", {27'd0, sel_a}, 32'd20);
    check("pc.valid", {31'd0, val_a}, 32'd1);

    // Single-source sweep over every index.
    for (int i = 0; i < NS; i++) set_word(i, 32'h1000_0000 + i);
    for (int i = 0; i < NS; i++) begin
      src_out = 24'h1 << i;
      tick();
      check($sformatf("sweep%0d.bus", i), bus_a, 32'h1000_0000 + i);
      check($sformatf("sweep%0d.sel", i), {27'd0, sel_a}, i);
      check($sformatf("sweep%0d.conflict", i), {31'd0, cf_a}, 32'd0);
    end

    // Idle hold versus return-to-zero.
    set_word(21, 32'hDEAD_BEEF);
    src_out = 24'h1 << 21;
    tick();
    src_out = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("idle%0d.hold_bus", k), bus_a, 32'hDEAD_BEEF);
      check($sformatf("idle%0d.hold_valid", k), {31'd0, val_a}, 32'd0);
      check($sformatf("idle%0d.nohold_bus", k), bus_b, 32'd0);
    end

    // Table of conflict / priority / err_clr vectors from a clean reset.
    set_word(3, 32'h0000_0033);
    set_word(16, 32'h0000_0016);
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      src_out = vecs[i].so;
      err_clr = vecs[i].ec;
      tick();
      check($sformatf("vec%0d.bus", i), bus_a, vecs[i].bus);
      check($sformatf("vec%0d.sel", i), {27'd0, sel_a}, {27'd0, vecs[i].sel});
      check($sformatf("vec%0d.valid", i), {31'd0, val_a}, {31'd0, vecs[i].v});
      check($sformatf("vec%0d.conflict", i), {31'd0, cf_a}, {31'd0, vecs[i].c});
      check($sformatf("vec%0d.sticky", i), {31'd0, st_a}, {31'd0, vecs[i].s});
      check($sformatf("vec%0d.cnt", i), {24'd0, cnt_a}, {24'd0, vecs[i].cnt});
    end
    err_clr = 1'b0;

    // Two-bit counter saturation, then clear colliding with a conflict.
    pulse_reset();
    src_out = 24'h010008;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("sat%0d.cnt", k), {30'd0, cnt_c}, (k < 3) ? k + 1 : 3);
    end
    err_clr = 1'b1;
    tick();
    check("clr_collide.cnt", {30'd0, cnt_c}, 32'd1);
    check("clr_collide.sticky", {31'd0, st_c}, 32'd1);
    src_out = '0;
    tick();
    check("clr_alone.cnt", {30'd0, cnt_c}, 32'd0);
    check("clr_alone.sticky", {31'd0, st_c}, 32'd0);
    err_clr = 1'b0;

    // Randomized traffic against the models.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NS; i++) set_word(i, $urandom());
      case ($urandom_range(0, 3))
        0:       src_out = '0;
        1:       src_out = 24'h1 << $urandom_range(0, NS - 1);
        default: src_out = NS'($urandom());
      endcase
      err_clr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_source_mux_reg.md
Name: bus_source_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Sources drive the shared CPU bus through one-hot "out" strobes (R0out..R15out, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InPortout, Cout) instead of a pre-encoded select.
- Block resolves strobes by fixed priority, registers the selected word onto the bus, optionally keeps the last value when nothing drives, and detects and counts multi-driver conflicts for debug.

Parameters:
- WIDTH, 32, bus/source data width in bits.
- N_SRC, 24, number of bus sources (index 0 = highest priority).
- HOLD_EN, 1, 1 = bus keeps last driven value when idle; 0 = bus returns to zero when idle.
- CNT_W, 8, width of saturating conflict counter.
- SEL_W (localparam), $clog2(N_SRC), width of the source index.

Ports:
- clk, input, 1, system clock, rising edge.
- clr, input, 1, asynchronous active-high reset.
- src_data, input, N_SRC*WIDTH, packed source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_out, input, N_SRC, one-hot drive strobes; bit i requests source i.
- err_clr, input, 1, synchronous clear of conflict_sticky and conflict_cnt.
- bus_out, output, WIDTH, registered bus value.
- bus_valid, output, 1, registered; 1 when bus_out was loaded from a source in the previous cycle.
- bus_sel, output, SEL_W, registered index of the source that drove bus_out.
- conflict, output, 1, registered one-cycle flag: previous cycle had more than one strobe set.
- conflict_sticky, output, 1, set on any conflict, held until err_clr or clr.
- conflict_cnt, output, CNT_W, saturating count of conflict cycles.

Behaviour:
- Reset (clr=1, asynchronous):
  - bus_out=0, bus_valid=0, bus_sel=0, conflict=0, conflict_sticky=0, conflict_cnt=0.
  - Outputs stay at reset values while clr is high; normal operation resumes on the first rising edge after clr falls.
- Resolution (combinational, each cycle):
  - any = |src_out.
  - idx = lowest set bit index of src_out.
  - multi = more than one bit set.
- Latency: exactly 1 clock from strobe to bus_out/bus_valid/bus_sel. No combinational path from inputs to outputs.
- On each rising edge with any=1:
  - bus_out <= src_data word idx.
  - bus_sel <= idx.
  - bus_valid <= 1.
- On each rising edge with any=0:
  - bus_valid <= 0; bus_sel holds.
  - bus_out holds if HOLD_EN=1, else bus_out <= 0.
- Conflict (multi=1):
  - Priority still applies; lowest index drives the bus.
  - conflict <= 1 for one cycle; conflict_sticky <= 1.
  - conflict_cnt increments; saturates at 2^CNT_W-1 with no wrap.
- err_clr:
  - Clears sticky and counter on the edge.
  - If err_clr and multi are high in the same cycle, the new conflict is counted after the clear: conflict_cnt=1, conflict_sticky=1.
  - The registered conflict pulse is unaffected by err_clr.
- Source indices at or above N_SRC do not exist; src_out width bounds them.
- src_data of non-selected sources has no effect (no X propagation onto bus_out).
- No state machine beyond these registers; all registers share clk/clr.

Decomposition:
- Shared package cpu_bus_pkg:
  - Source index constants SRC_R0..SRC_R15 = 0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_CSIGN=23.
  - N_SRC_DEFAULT=24, WORD_W=32.
- One sub-module, bus_prio_encoder:
  - Parametrised on N_SRC.
  - Combinational; one-hot vector in, idx/any/multi out.
  - Reused later by the control unit.

Test Plan:
- Reset: assert clr mid-operation while bus_out=0x0000_00A5 → all outputs 0 immediately without a clock edge; hold clr low then set src_out=bit 20 with PC word=0x0000_0100 → next edge bus_out=0x100, bus_sel=20, bus_valid=1.
- Single source sweep: for i=0..23, src_data word i=0x1000_0000+i, one-hot strobe i → one cycle later bus_out=0x1000_0000+i, bus_sel=i, conflict=0. Covers index 11 and index 23 (Cout) explicitly.
- Idle hold, HOLD_EN=1: MDR (21) drives 0xDEAD_BEEF, then src_out=0 for 3 cycles → bus_out stays 0xDEAD_BEEF, bus_valid=0. With HOLD_EN=0, same stimulus → bus_out=0 one cycle after the strobe drops.
- Conflict priority: strobes 3 and 16 with R3=0x33, HI=0x16 → bus_out=0x33, bus_sel=3, conflict=1 for one cycle, conflict_sticky=1, conflict_cnt=1; following clean cycle → conflict=0, sticky still 1.
- Counter saturation: CNT_W=2, 5 consecutive conflict cycles → conflict_cnt reads 1,2,3,3,3.
- err_clr collision: err_clr=1 in the same cycle as a conflict, with cnt=3 → cnt=1, sticky=1. err_clr alone next cycle → cnt=0, sticky=0.
